// File: rtl/locking_rr_arbiter_param.sv
// N-input round-robin arbiter with multi-beat locking. A first beat that carries
// has_data holds the grant on that input for BEATS transfers, so messages stay contiguous.
module locking_rr_arbiter_param #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int BEATS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N-1:0]                       io_in_valid,
    output logic [N-1:0]                       io_in_ready,
    input  logic [N*W-1:0]                     io_in_bits,
    input  logic [N-1:0]                       io_in_has_data,
    output logic                               io_out_valid,
    input  logic                               io_out_ready,
    output logic [W-1:0]                       io_out_bits,
    output logic                               io_out_has_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] io_chosen,
    output logic                               io_locked
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] last_grant;
    logic [CW-1:0] lock_idx;
    logic          locked;
    logic [BW-1:0] beat_cnt;

    logic [CW-1:0] chosen;
    logic [CW-1:0] idx_hi;
    logic [CW-1:0] idx_any;
    logic          found_hi;
    logic          found_any;
    logic          fire;

    // Round-robin pick: first valid above last_grant, else wrap to lowest valid.
    // While locked, the lock owner is held even if its valid drops.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int i = 0; i < N; i++) begin
            if (io_in_valid[i] && !found_any) begin
                found_any = 1'b1;
                idx_any   = CW'(i);
            end
            if (io_in_valid[i] && !found_hi && (i > int'(last_grant))) begin
                found_hi = 1'b1;
                idx_hi   = CW'(i);
            end
        end
        if (locked)
            chosen = lock_idx;
        else if (found_hi)
            chosen = idx_hi;
        else
            chosen = idx_any;
    end

    always_comb begin
        io_out_valid    = 1'b0;
        io_out_bits     = '0;
        io_out_has_data = 1'b0;
        io_in_ready     = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(chosen) == i) begin
                io_out_valid    = io_in_valid[i];
                io_out_bits     = io_in_bits[i*W +: W];
                io_out_has_data = io_in_has_data[i];
                io_in_ready[i]  = io_out_ready;
            end
        end
    end

    assign fire      = io_out_valid & io_out_ready;
    assign io_chosen = chosen;
    assign io_locked = locked;

    // has_data is only looked at on an unlocked (first) beat; later beats just count.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= CW'(N - 1);
            locked     <= 1'b0;
            lock_idx   <= '0;
            beat_cnt   <= '0;
        end else if (fire) begin
            last_grant <= chosen;
            if (!locked) begin
                if (io_out_has_data && (BEATS > 1)) begin
                    locked   <= 1'b1;
                    lock_idx <= chosen;
                    beat_cnt <= BW'(1);
                end
            end else if (beat_cnt == BW'(BEATS - 1)) begin
                locked   <= 1'b0;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_locking_rr_arbiter_param.sv
// Directed bench for locking_rr_arbiter_param (N=4, W=32, BEATS=4): rotation,
// skipping, locked bursts, backpressure, valid drop and reset mid-burst.
module tb_locking_rr_arbiter_param;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int BEATS = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   io_in_valid;
    logic [N-1:0]   io_in_ready;
    logic [N*W-1:0] io_in_bits;
    logic [N-1:0]   io_in_has_data;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out_bits;
    logic           io_out_has_data;
    logic [1:0]     io_chosen;
    logic           io_locked;

    int vectors;
    int miscompares;

    locking_rr_arbiter_param #(.N(N), .W(W), .BEATS(BEATS)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_in_valid    (io_in_valid),
        .io_in_ready    (io_in_ready),
        .io_in_bits     (io_in_bits),
        .io_in_has_data (io_in_has_data),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_bits    (io_out_bits),
        .io_out_has_data(io_out_has_data),
        .io_chosen      (io_chosen),
        .io_locked      (io_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; checks run #1 later, well before the rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        io_in_valid    = '0;
        io_in_has_data = '0;
        io_out_ready   = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (io_locked !== 1'b0 || io_chosen !== 2'd0 || io_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: locked=%b chosen=%0d out_valid=%b, want 0/0/0",
                     io_locked, io_chosen, io_out_valid);
        end
        io_in_valid = 4'b0100;
        #1;
        vectors++;
        if (io_chosen !== 2'd2 || io_out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_lowest_valid: chosen=%0d out_valid=%b, want 2/1",
                     io_chosen, io_out_valid);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        io_in_valid  = 4'b1111;
        io_out_ready = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            vectors++;
            if (io_chosen !== exp_seq[s]) begin
                miscompares++;
                $display("[TB] FAIL rot_chosen step %0d: got %0d, want %0d", s, io_chosen, exp_seq[s]);
            end
            vectors++;
            if (io_in_ready !== (4'b0001 << exp_seq[s])) begin
                miscompares++;
                $display("[TB] FAIL rot_ready step %0d: got %b, want %b", s, io_in_ready,
                         4'b0001 << exp_seq[s]);
            end
            vectors++;
            if (io_out_bits !== (32'hC0DE_0000 + 32'(exp_seq[s])) || io_out_has_data !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rot_bits step %0d: got %h/%b, want %h/0", s, io_out_bits,
                         io_out_has_data, 32'hC0DE_0000 + 32'(exp_seq[s]));
            end
            tick();
        end
    endtask

    task automatic test_skip();
        do_reset();
        io_out_ready = 1'b1;
        io_in_valid  = 4'b0010;
        tick();
        io_in_valid = 4'b1001;
        #1;
        vectors++;
        if (io_chosen !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL skip_first: got %0d, want 3", io_chosen);
        end
        tick();
        vectors++;
        if (io_chosen !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL skip_wrap: got %0d, want 0", io_chosen);
        end
    endtask

    task automatic test_lock();
        do_reset();
        io_out_ready = 1'b1;
        io_in_valid  = 4'b0010;
        tick();
        io_in_valid    = 4'b0111;
        io_in_has_data = 4'b0100;
        #1;
        vectors++;
        if (io_chosen !== 2'd2 || io_locked !== 1'b0 || io_out_has_data !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lock_beat1: chosen=%0d locked=%b hd=%b, want 2/0/1",
                     io_chosen, io_locked, io_out_has_data);
        end
        tick();
        io_in_has_data = 4'b0000;
        for (int b = 2; b <= 4; b++) begin
            #1;
            vectors++;
            if (io_chosen !== 2'd2 || io_locked !== 1'b1 || io_in_ready !== 4'b0100) begin
                miscompares++;
                $display("[TB] FAIL lock_beat%0d: chosen=%0d locked=%b ready=%b, want 2/1/0100",
                         b, io_chosen, io_locked, io_in_ready);
            end
            tick();
        end
        vectors++;
        if (io_locked !== 1'b0 || io_chosen !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL lock_release: locked=%b chosen=%0d, want 0/0", io_locked, io_chosen);
        end
        io_in_valid = 4'b1111;
        #1;
        vectors++;
        if (io_chosen !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL lock_next_rr: got %0d, want 3", io_chosen);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        io_out_ready = 1'b1;
        io_in_valid  = 4'b0010;
        tick();
        io_in_valid    = 4'b0111;
        io_in_has_data = 4'b0100;
        tick();
        tick();
        io_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (io_chosen !== 2'd2 || io_locked !== 1'b1 || io_out_valid !== 1'b1 ||
                io_in_ready !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d: chosen=%0d locked=%b ov=%b ready=%b, want 2/1/1/0000",
                         c, io_chosen, io_locked, io_out_valid, io_in_ready);
            end
            tick();
        end
        io_out_ready = 1'b1;
        tick();
        vectors++;
        if (io_locked !== 1'b1 || io_chosen !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL bp_beat3: locked=%b chosen=%0d, want 1/2", io_locked, io_chosen);
        end
        tick();
        vectors++;
        if (io_locked !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_done: locked=%b, want 0", io_locked);
        end
    endtask

    task automatic test_valid_drop();
        do_reset();
        io_out_ready   = 1'b1;
        io_in_valid    = 4'b0010;
        io_in_has_data = 4'b0010;
        tick();
        io_in_valid    = 4'b0001;
        io_in_has_data = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (io_out_valid !== 1'b0 || io_in_ready[0] !== 1'b0 || io_chosen !== 2'd1 ||
                io_locked !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL drop_hold cycle %0d: ov=%b ready=%b chosen=%0d locked=%b, want 0/xx0/1/1",
                         c, io_out_valid, io_in_ready, io_chosen, io_locked);
            end
            tick();
        end
        io_in_valid = 4'b0011;
        #1;
        vectors++;
        if (io_out_valid !== 1'b1 || io_chosen !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL drop_resume: ov=%b chosen=%0d, want 1/1", io_out_valid, io_chosen);
        end
        tick();
        tick();
        vectors++;
        if (io_locked !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drop_beat4_locked: got %b, want 1", io_locked);
        end
        tick();
        vectors++;
        if (io_locked !== 1'b0 || io_chosen !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL drop_done: locked=%b chosen=%0d, want 0/0", io_locked, io_chosen);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        io_out_ready = 1'b1;
        io_in_valid  = 4'b0100;
        tick();
        io_in_valid    = 4'b1111;
        io_in_has_data = 4'b1000;
        #1;
        vectors++;
        if (io_chosen !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL rmb_first: chosen=%0d, want 3", io_chosen);
        end
        tick();
        vectors++;
        if (io_locked !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rmb_locked: got %b, want 1", io_locked);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (io_locked !== 1'b0 || io_chosen !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL rmb_after_reset: locked=%b chosen=%0d, want 0/0", io_locked, io_chosen);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < N; i++)
            io_in_bits[i*W +: W] = 32'hC0DE_0000 + 32'(i);
        reset          = 1'b1;
        io_in_valid    = '0;
        io_in_has_data = '0;
        io_out_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_skip();
        test_lock();
        test_backpressure();
        test_valid_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/locking_rr_arbiter_param.md
Name: locking_rr_arbiter_param

Overview:
- Parametrised N-input round-robin arbiter with real multi-beat locking. Successor to the fixed 4-input single-beat arbiter used in the coherence/network path.
- When a granted first beat carries has_data, the grant is held on that input for BEATS consecutive transfers. This keeps multi-beat messages contiguous at the output.
- Sits in front of a shared channel, e.g. an acquire/release network port.

Parameters:
- N, 4, number of requesting inputs (>=1).
- W, 32, payload width per input in bits (header and payload packed by the user).
- BEATS, 4, beats per locked message (>=1). BEATS=1 disables locking.
- CW, clog2(N) with minimum 1, width of the chosen index. Derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  N  per-input valid.
- io_in_ready  out  N  per-input ready.
- io_in_bits  in  N*W  packed payloads; input i occupies [i*W +: W].
- io_in_has_data  in  N  per-input flag; 1 = multi-beat message (sampled on the first beat only).
- io_out_valid  out  1  output valid.
- io_out_ready  in  1  output ready.
- io_out_bits  out  W  payload of the chosen input.
- io_out_has_data  out  1  has_data of the chosen input.
- io_chosen  out  CW  index currently selected.
- io_locked  out  1  grant is locked mid-message.

Behaviour:
- State: lastGrant (CW bits), locked (1 bit), lockIdx (CW bits), beatCnt (clog2(BEATS) bits, minimum 1).
- Reset (synchronous): lastGrant=N-1, locked=0, lockIdx=0, beatCnt=0.
- Reset values of the state-driven outputs: io_locked=0, and io_chosen equals the lowest valid index (0 if none valid).
- Choice, unlocked: io_chosen = lowest index i > lastGrant with io_in_valid[i]; if none, lowest index with io_in_valid set; if no input is valid, 0.
- Choice, locked: io_chosen = lockIdx regardless of any valid bits.
- io_out_valid = io_in_valid[io_chosen]. io_out_bits and io_out_has_data are muxed by io_chosen. All are combinational; zero latency.
- io_in_ready[i] = io_out_ready & (i == io_chosen). At most one ready is high per cycle.
- ready never depends on the valid of a different input once locked.
- fire = io_out_valid & io_out_ready.
- On fire: lastGrant <= io_chosen.
- On fire, unlocked, io_out_has_data=1, BEATS>1: locked <= 1, lockIdx <= io_chosen, beatCnt <= 1.
- On fire, locked: if beatCnt == BEATS-1, then locked <= 0 and beatCnt <= 0; otherwise beatCnt <= beatCnt+1.
- No fire: all state holds, including under backpressure and when the locked input drops valid. In that case io_out_valid=0 and no other input is granted.
- has_data on non-first beats is ignored.
- BEATS=1: locked is never set; io_locked is constant 0.
- N=1: io_chosen is constant 0; the arbiter acts as a pass-through with the locking counter still active.
- Reset has priority over fire in the same cycle. Reset mid-burst abandons the lock; the next grant follows the reset lastGrant (index 0 first).

Test Plan:
1. N=4, BEATS=4. After reset, all four inputs valid with has_data=0 and out_ready=1 for 5 cycles -> io_chosen sequence 0,1,2,3,0; exactly one io_in_ready high per cycle.
2. Single grant to input 1 (lastGrant=1). Then only inputs 0 and 3 valid, out_ready=1 -> chosen 3, then 0.
3. Input 2 first beat has_data=1; inputs 0,1,2 valid continuously -> chosen=2 for 4 fires; io_locked=1 during beats 2-4; io_in_ready[0]=io_in_ready[1]=0 throughout. After the 4th fire, io_locked=0 and the next chosen is 3 if valid, else 0.
4. Same burst, out_ready held low for 3 cycles after beat 2 -> beatCnt holds at 2, chosen stays 2. Once out_ready returns, burst completes in 2 more fires.
5. Locked on input 1; input 1 valid low for 2 cycles while input 0 valid -> io_out_valid=0, io_in_ready[0]=0. Burst resumes on input 1 when its valid returns.
6. reset asserted for 1 cycle after beat 1 of a locked burst on input 3, all inputs valid -> io_locked=0 next cycle; first grant after reset is input 0.
